seg_scan_driver: RTL

- Parametrised, time-multiplexed driver for a DIGITS-wide seven-segment display bank.
- Accepts one 5-bit display code per digit (hex digits, blank, elevator up/down arrows) and decodes it to a segment pattern.
- Scans the digits one at a time, adding anti-ghosting guard time, tear-free frame-synchronous updates, per-digit decimal point and per-digit blinking.
- Sits between the elevator controller's floor/direction logic and the board's segment/anode pins.

---
 rtl/seg_pkg.sv | 61 ++++++
 rtl/seg_decode.sv | 26 ++
 rtl/seg_scan_driver.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: display code values
// and the segment patterns they map to. Patterns are {a,b,c,d,e,f,g,h}
// with a as MSB; bit h (decimal point) is always 0 here and is merged
// in separately by the driver.
package seg_pkg;

    // Display codes (5 bits). Bit 4 set means "hex digit in bits 3:0".
    localparam logic [4:0] CODE_BLANK  = 5'b00000;
    localparam logic [4:0] CODE_UP     = 5'b00001;
    localparam logic [4:0] CODE_DOWN   = 5'b00010;
    localparam logic [4:0] CODE_UPDOWN = 5'b00011;
    localparam int         HEX_FLAG    = 4;

    // Segment patterns
    localparam logic [7:0] SEG_OFF    = 8'h00;
    localparam logic [7:0] SEG_UP     = 8'hC0;
    localparam logic [7:0] SEG_DOWN   = 8'h18;
    localparam logic [7:0] SEG_UPDOWN = 8'hD8;

    localparam logic [7:0] SEG_HEX_0 = 8'hFC;
    localparam logic [7:0] SEG_HEX_1 = 8'h60;
    localparam logic [7:0] SEG_HEX_2 = 8'hDA;
    localparam logic [7:0] SEG_HEX_3 = 8'hF2;
    localparam logic [7:0] SEG_HEX_4 = 8'h66;
    localparam logic [7:0] SEG_HEX_5 = 8'hB6;
    localparam logic [7:0] SEG_HEX_6 = 8'hBE;
    localparam logic [7:0] SEG_HEX_7 = 8'hE0;
    localparam logic [7:0] SEG_HEX_8 = 8'hFE;
    localparam logic [7:0] SEG_HEX_9 = 8'hF6;
    localparam logic [7:0] SEG_HEX_A = 8'hEE;
    localparam logic [7:0] SEG_HEX_B = 8'h3E;
    localparam logic [7:0] SEG_HEX_C = 8'h9C;
    localparam logic [7:0] SEG_HEX_D = 8'h7A;
    localparam logic [7:0] SEG_HEX_E = 8'h9E;
    localparam logic [7:0] SEG_HEX_F = 8'h8E;

    // Hex nibble to segment pattern (lower-case b and d shapes for 0xB/0xD).
    function automatic logic [7:0] hex_pattern(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'h0: pat = SEG_HEX_0;
            4'h1: pat = SEG_HEX_1;
            4'h2: pat = SEG_HEX_2;
            4'h3: pat = SEG_HEX_3;
            4'h4: pat = SEG_HEX_4;
            4'h5: pat = SEG_HEX_5;
            4'h6: pat = SEG_HEX_6;
            4'h7: pat = SEG_HEX_7;
            4'h8: pat = SEG_HEX_8;
            4'h9: pat = SEG_HEX_9;
            4'hA: pat = SEG_HEX_A;
            4'hB: pat = SEG_HEX_B;
            4'hC: pat = SEG_HEX_C;
            4'hD: pat = SEG_HEX_D;
            4'hE: pat = SEG_HEX_E;
            default: pat = SEG_HEX_F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational display-code decoder: 5-bit code to 8-bit segment pattern.
// Unused non-hex codes decode to all segments off.
module seg_decode
    import seg_pkg::*;
(
    input  logic [4:0] code,
    output logic [7:0] pattern
);

    // Hex digits take priority; otherwise match the arrow symbols.
    always_comb begin
        pattern = SEG_OFF;
        if (code[HEX_FLAG]) begin
            pattern = hex_pattern(code[3:0]);
        end else begin
            case (code)
                CODE_BLANK:  pattern = SEG_OFF;
                CODE_UP:     pattern = SEG_UP;
                CODE_DOWN:   pattern = SEG_DOWN;
                CODE_UPDOWN: pattern = SEG_UPDOWN;
                default:     pattern = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver. Scans DIGITS digits, SCAN_DIV
// clocks each, blanking the first GUARD clocks of every slot to avoid
// ghosting. New content is staged in pending registers and copied to the
// display registers only at a frame boundary so a frame never tears.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int GUARD          = 2,
    parameter int BLINK_FRAMES   = 250,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [5*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = $clog2(DIGITS);
    localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0] GUARD_END = SCAN_W'(GUARD);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [DIGITS-1:0] DIG_OFF   =
        (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // Scan state
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [FRM_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic                blink_phase_q, blink_phase_d;

    // Pending (staging) and display registers
    logic [5*DIGITS-1:0] pend_data_q, pend_data_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [DIGITS-1:0]   pend_blink_q, pend_blink_d;
    logic [5*DIGITS-1:0] disp_data_q, disp_data_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [DIGITS-1:0]   disp_blink_q, disp_blink_d;

    // Output stage
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;
    logic                frame_done_q, frame_done_d;

    // Helpers
    logic                slot_end;
    logic                frame_end;
    logic                commit;
    logic [4:0]          code_arr [DIGITS];
    logic [4:0]          cur_code;
    logic [7:0]          cur_pattern;
    logic                cur_dp;
    logic                cur_blink;
    logic [DIGITS-1:0]   dig_on;

    assign slot_end  = (scan_cnt_q == SCAN_LAST);
    assign frame_end = enable && slot_end && (idx_q == IDX_LAST);
    // While dark the display registers track the pending ones continuously.
    assign commit    = frame_end || !enable;

    // Split the packed display codes into per-digit entries for the index mux,
    // and build the one-hot active-high select for the current index.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign code_arr[gi] = disp_data_q[5*gi +: 5];
            assign dig_on[gi]   = enable && (idx_q == IDX_W'(gi));
        end
    endgenerate

    assign cur_code  = code_arr[idx_q];
    assign cur_dp    = disp_dp_q[idx_q];
    assign cur_blink = disp_blink_q[idx_q];

    seg_decode u_decode (
        .code    (cur_code),
        .pattern (cur_pattern)
    );

    // Slot/digit/frame counters and blink phase; all cleared while disabled.
    always_comb begin
        scan_cnt_d    = scan_cnt_q;
        idx_d         = idx_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (!enable) begin
            scan_cnt_d    = '0;
            idx_d         = '0;
            frame_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else begin
            if (slot_end) begin
                scan_cnt_d = '0;
                idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                scan_cnt_d = scan_cnt_q + 1'b1;
            end
            if (frame_end) begin
                if (frame_cnt_q == FRM_LAST) begin
                    frame_cnt_d   = '0;
                    blink_phase_d = !blink_phase_q;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
        end
    end

    // Pending capture and frame-synchronous display transfer; a load on the
    // transfer edge bypasses the pending registers so it is not lost.
    always_comb begin
        pend_data_d  = load ? data_in    : pend_data_q;
        pend_dp_d    = load ? dp_mask    : pend_dp_q;
        pend_blink_d = load ? blink_mask : pend_blink_q;
        disp_data_d  = disp_data_q;
        disp_dp_d    = disp_dp_q;
        disp_blink_d = disp_blink_q;
        if (commit) begin
            disp_data_d  = load ? data_in    : pend_data_q;
            disp_dp_d    = load ? dp_mask    : pend_dp_q;
            disp_blink_d = load ? blink_mask : pend_blink_q;
        end
    end

    // Registered outputs: guard blanking, blink blanking, dp merge, select.
    always_comb begin
        seg_d = SEG_OFF;
        if (enable && !(scan_cnt_q < GUARD_END) && !(blink_phase_q && cur_blink)) begin
            seg_d = {cur_pattern[7:1], cur_dp};
        end
        dig_sel_d    = dig_on ^ DIG_OFF;
        frame_done_d = frame_end;
    end

    // State and output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q    <= '0;
            idx_q         <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            pend_data_q   <= '0;
            pend_dp_q     <= '0;
            pend_blink_q  <= '0;
            disp_data_q   <= '0;
            disp_dp_q     <= '0;
            disp_blink_q  <= '0;
            seg_q         <= SEG_OFF;
            dig_sel_q     <= DIG_OFF;
            frame_done_q  <= 1'b0;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            idx_q         <= idx_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            pend_data_q   <= pend_data_d;
            pend_dp_q     <= pend_dp_d;
            pend_blink_q  <= pend_blink_d;
            disp_data_q   <= disp_data_d;
            disp_dp_q     <= disp_dp_d;
            disp_blink_q  <= disp_blink_d;
            seg_q         <= seg_d;
            dig_sel_q     <= dig_sel_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign seg_out    = seg_q;
    assign dig_sel    = dig_sel_q;
    assign frame_done = frame_done_q;

endmodule
